button_step_pulse: RTL and testbench

Synchronises, debounces and edge-detects one mechanical push-button, producing single-cycle step pulses in the `CLK` domain, with optional auto-repeat while the button is held. It sits directly upstream of the display-data counter, which increments on `step_pulse` as a synchronous clock enable rather than clocking on a button edge. A debounced level and a release pulse are also provided for other front-panel logic.

---
 rtl/ui_pkg.sv | 22 ++
 rtl/sync_debounce.sv | 63 ++++++
 rtl/button_step_pulse.sv | 117 +++++++++++
 tb/tb_button_step_pulse.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared FSM encoding and counter sizing for front-panel button logic
// Contents:
//   ST_*_ENC    : state encodings for the hold/repeat FSM
//   ui_state_t  : FSM state type built from those encodings
//   cnt_width() : bits needed for a counter that must hold values 0..max_val
package ui_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_HELD_ENC   = 2'd1;
    localparam logic [1:0] ST_REPEAT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_HELD   = ST_HELD_ENC,
        ST_REPEAT = ST_REPEAT_ENC
    } ui_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser plus counter debounce for one button
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   button       : raw asynchronous button level
//   pressed      : debounced level
//   rise, fall   : registered one-cycle pulses, high in the first cycle of a new pressed level
//   press_acc    : combinational, pressed will go 1 on the coming edge
//   release_acc  : combinational, pressed will go 0 on the coming edge
module sync_debounce
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pressed,
    output logic rise,
    output logic fall,
    output logic press_acc,
    output logic release_acc
);

    localparam int              DW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          btn_s;
    logic [DW-1:0] cnt;
    logic          mismatch;
    logic          accept;

    assign mismatch    = (btn_s != pressed);
    // The counter never passes D_LAST: acceptance clears it on the same edge.
    assign accept      = mismatch && (cnt == D_LAST);
    assign press_acc   = accept && !pressed;
    assign release_acc = accept && pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            btn_s   <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            meta  <= button;
            btn_s <= meta;
            rise  <= press_acc;
            fall  <= release_acc;
            if (accept) begin
                pressed <= ~pressed;
                cnt     <= '0;
            end else if (mismatch) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_step_pulse.sv
// rtl/button_step_pulse.sv - debounced button to single-cycle step pulses with auto-repeat
// Ports:
//   CLK           : clock, all logic on rising edge
//   clr           : asynchronous active-low reset
//   button        : raw asynchronous button, active-high
//   pressed       : debounced level
//   press_pulse   : one cycle per accepted press
//   release_pulse : one cycle per accepted release
//   step_pulse    : press_pulse OR auto-repeat pulse
module button_step_pulse
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int REPEAT_EN       = 1
) (
    input  logic CLK,
    input  logic clr,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);

    localparam int            MAX_HR      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            CW          = cnt_width(MAX_HR);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic rise;
    logic fall;
    logic press_acc;
    logic release_acc;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (CLK),
        .rst_n      (clr),
        .button     (button),
        .pressed    (pressed),
        .rise       (rise),
        .fall       (fall),
        .press_acc  (press_acc),
        .release_acc(release_acc)
    );

    ui_state_t     state;
    ui_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          rep_fire;
    logic          rep_pulse;

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rep_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rep_pulse <= rep_fire;
        end
    end

    // The FSM moves on the acceptance edge itself, so the counter starts in
    // the press_pulse cycle and the first repeat lands HOLD_CYCLES later.
    // Release is tested first in every held state so it always beats a repeat.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rep_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (press_acc) begin
                    state_n = ST_HELD;
                end
            end
            ST_HELD: begin
                if (release_acc) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if ((REPEAT_EN != 0) && (cnt == HOLD_LAST)) begin
                    state_n  = ST_REPEAT;
                    cnt_n    = '0;
                    rep_fire = 1'b1;
                end else if (cnt != HOLD_LAST) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (release_acc) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_n    = '0;
                    rep_fire = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign press_pulse   = rise;
    assign release_pulse = fall;
    assign step_pulse    = rise | rep_pulse;

endmodule

// File: tb/tb_button_step_pulse.sv
// tb/tb_button_step_pulse.sv - scoreboard bench for button_step_pulse
module tb_button_step_pulse;
    import ui_pkg::*;

    logic CLK = 1'b0;
    logic clr;
    logic button;
    logic pressed, press_pulse, release_pulse, step_pulse;
    logic nr_pressed, nr_press_pulse, nr_release_pulse, nr_step_pulse;

    always #5 CLK = ~CLK;

    button_step_pulse #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
    ) dut (
        .CLK(CLK), .clr(clr), .button(button), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .step_pulse(step_pulse)
    );

    button_step_pulse #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(0)
    ) dut_norep (
        .CLK(CLK), .clr(clr), .button(button), .pressed(nr_pressed),
        .press_pulse(nr_press_pulse), .release_pulse(nr_release_pulse), .step_pulse(nr_step_pulse)
    );

    typedef struct {
        int   cyc;
        logic prs;
        logic pp;
        logic rp;
        logic sp;
    } ev_t;

    ev_t q[$];
    int  q0[$];
    int  cyc = 0;
    int  vectors = 0;
    int  fails = 0;
    logic done = 1'b0;
    int  t0, t1, c1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic push_ev(input int c, input logic prs, input logic pp, input logic rp, input logic sp);
        ev_t e;
        e.cyc = c; e.prs = prs; e.pp = pp; e.rp = rp; e.sp = sp;
        q.push_back(e);
    endtask

    task automatic exp_press(input int c);
        push_ev(c, 1'b1, 1'b1, 1'b0, 1'b1);
        q0.push_back(c);
    endtask

    task automatic exp_repeat(input int c);
        push_ev(c, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic exp_release(input int c);
        push_ev(c, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    always @(negedge CLK) begin
        ev_t e;
        int  c0;
        if (!clr) begin
            vectors = vectors + 1;
            if ({pressed, press_pulse, release_pulse, step_pulse,
                 nr_pressed, nr_press_pulse, nr_release_pulse, nr_step_pulse} != 8'h00) begin
                fails = fails + 1;
                $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b_%b%b%b%b expected=0000_0000", cyc,
                         pressed, press_pulse, release_pulse, step_pulse,
                         nr_pressed, nr_press_pulse, nr_release_pulse, nr_step_pulse);
            end
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                vectors = vectors + 1;
                fails = fails + 1;
                $display("FAIL missing_event got=none expected cyc=%0d pp=%b rp=%b sp=%b", e.cyc, e.pp, e.rp, e.sp);
            end
            while (q0.size() > 0 && q0[0] < cyc) begin
                c0 = q0.pop_front();
                vectors = vectors + 1;
                fails = fails + 1;
                $display("FAIL missing_norep_step got=none expected cyc=%0d", c0);
            end
            if (press_pulse || release_pulse || step_pulse) begin
                vectors = vectors + 1;
                if (q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_event cyc=%0d got pp=%b rp=%b sp=%b expected=none",
                             cyc, press_pulse, release_pulse, step_pulse);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.prs != pressed || e.pp != press_pulse ||
                        e.rp != release_pulse || e.sp != step_pulse) begin
                        fails = fails + 1;
                        $display("FAIL event got cyc=%0d prs=%b pp=%b rp=%b sp=%b expected cyc=%0d prs=%b pp=%b rp=%b sp=%b",
                                 cyc, pressed, press_pulse, release_pulse, step_pulse,
                                 e.cyc, e.prs, e.pp, e.rp, e.sp);
                    end
                    if (e.rp) begin
                        vectors = vectors + 1;
                        if (dut.state != ST_IDLE) begin
                            fails = fails + 1;
                            $display("FAIL state_after_release cyc=%0d got=%0d expected=%0d",
                                     cyc, dut.state, ST_IDLE);
                        end
                    end
                end
            end
            if (nr_step_pulse) begin
                vectors = vectors + 1;
                if (q0.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL norep_unexpected_step cyc=%0d got=1 expected=0", cyc);
                end else begin
                    c0 = q0.pop_front();
                    if (c0 != cyc || !nr_press_pulse) begin
                        fails = fails + 1;
                        $display("FAIL norep_step got cyc=%0d pp=%b expected cyc=%0d pp=1", cyc, nr_press_pulse, c0);
                    end
                end
            end
        end
        if (done) begin
            vectors = vectors + 1;
            if (q.size() != 0 || q0.size() != 0) begin
                fails = fails + 1;
                $display("FAIL drain got pending=%0d/%0d expected=0/0", q.size(), q0.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        button = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(3);

        // Clean press, held 10 cycles, release.
        button = 1'b1; t0 = cyc + 1;
        exp_press(t0 + 5);
        tick(10);
        button = 1'b0; t1 = cyc + 1;
        exp_release(t1 + 5);
        tick(12);

        // Bounce 1,0,1,0 then stable high.
        button = 1'b1; tick(1);
        button = 1'b0; tick(1);
        button = 1'b1; tick(1);
        button = 1'b0; tick(1);
        button = 1'b1; t0 = cyc + 1;
        exp_press(t0 + 5);
        tick(10);
        button = 1'b0; t1 = cyc + 1;
        exp_release(t1 + 5);
        tick(12);

        // Long hold: repeats on the enabled instance, a single step on the other.
        button = 1'b1; t0 = cyc + 1;
        exp_press(t0 + 5);
        for (int k = 0; k < 5; k++) exp_repeat(t0 + 25 + 8 * k);
        tick(55);
        button = 1'b0; t1 = cyc + 1;
        exp_release(t1 + 5);
        tick(12);

        // Reset mid-REPEAT with the button still held.
        button = 1'b1; t0 = cyc + 1;
        exp_press(t0 + 5);
        exp_repeat(t0 + 25);
        tick(30);
        clr = 1'b0;
        tick(3);
        clr = 1'b1; c1 = cyc;
        exp_press(c1 + 6);
        tick(8);
        button = 1'b0; t1 = cyc + 1;
        exp_release(t1 + 5);
        tick(12);

        // Release acceptance on the second repeat edge.
        button = 1'b1; t0 = cyc + 1;
        exp_press(t0 + 5);
        exp_repeat(t0 + 25);
        tick(28);
        button = 1'b0; t1 = cyc + 1;
        exp_release(t1 + 5);
        tick(25);

        done = 1'b1;
    end

endmodule
